mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
Two-requester arbiter sharing one single-ported memory between the program management side (port 0: instruction fetch and RA traffic) and the instruction execution side (port 1: data loads, stores and I/O buffers).
- Sequences each access through accept, issue, latency wait and response.
- Round-robin fairness between the two ports.
- Sits between the datapath subsystems and the memory macro; replaces direct dual-port wiring.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data word width
MEM_LAT, 1, memory read latency in cycles from mem_en to valid mem_rdata; legal range 0..7

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
req0_valid  in  1  port 0 request
req0_we  in  1  port 0 write (1) / read (0)
req0_addr  in  ADDR_W  port 0 address
req0_wdata  in  DATA_W  port 0 write data
req0_ready  out  1  port 0 request accepted this cycle
rsp0_valid  out  1  port 0 response pulse
rsp0_rdata  out  DATA_W  port 0 read data
req1_valid, req1_we, req1_addr, req1_wdata, req1_ready, rsp1_valid, rsp1_rdata: same as port 0, for port 1
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset is asynchronous, active-high:
  - state=IDLE, last_grant=1, so port 0 wins the first tie.
  - All registered outputs are 0.
  - reqN_ready is forced 0 while reset is high.
- FSM states and transitions:
  - IDLE: if any reqN_valid, pick a winner and assert reqN_ready combinationally that cycle (cycle T). Latch we/addr/wdata/port id; go to ISSUE.
  - ISSUE (T+1): mem_en=1, mem_we=latched we, mem_addr and mem_wdata from latches, for exactly 1 cycle. If MEM_LAT=0, capture mem_rdata this cycle and go to RESP; else go to WAIT.
  - WAIT: count MEM_LAT cycles; capture mem_rdata on the edge ending cycle T+1+MEM_LAT; go to RESP.
  - RESP (T+2+MEM_LAT): rspN_valid=1 for the granted port for 1 cycle, with rspN_rdata = captured data. Writes also pulse rsp as an acknowledgement, with rdata=0x0000. Return to IDLE.
- Latency is identical for reads and writes.
- Throughput: one access per MEM_LAT+3 cycles.
- mem_en, mem_we, mem_addr and mem_wdata are 0 outside ISSUE.
- Arbitration:
  - Single valid: that port wins.
  - Both valid: the port != last_grant wins.
  - last_grant updates only on accept.
- Handshake rules:
  - ready is asserted only in IDLE.
  - A requester holds valid and payload stable until ready.
  - Dropping valid before ready is legal; no grant results.
  - Responses have no backpressure; the requester must sample the pulse.
  - A new accept is possible in the IDLE cycle directly after RESP.
- rspN_rdata holds its last value between pulses.
- Reset mid-transaction: the access is abandoned, no response is issued, and the FSM returns to IDLE.

Optional Feature:
Macro: MEM_ARB_PERF_EN.
- Defined:
  - Adds outputs perf_grant0, perf_grant1 and perf_conflict, each 16 bits.
  - perf_grant0 and perf_grant1 are saturating accept counts.
  - perf_conflict is a saturating count of IDLE cycles with both valids high.
  - All three clear on reset and stick at 0xFFFF.
- Undefined: the ports and counter logic are absent; core behaviour is unchanged.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum IDLE/ISSUE/WAIT/RESP;
  - default widths;
  - MEM_LAT_MAX=7;
  - the latency counter width of 3.
- Sub-module mem_arb_rr2 is the 2-way round-robin pick: inputs valid0, valid1, last_grant; outputs grant and any.

Test Plan:
1. After reset, req0 read 0x0010 with the memory model returning 0xBEEF (MEM_LAT=1) -> req0_ready at T, mem_en with addr 0x0010 at T+1, rsp0_valid with 0xBEEF at T+3, busy high T+1..T+3.
2. req0 and req1 both valid continuously, 4 accesses each -> grant order 0,1,0,1,0,1,0,1; accepts spaced 4 cycles apart.
3. req1 write 0x0020=0x1234, then req1 read 0x0020 -> mem_we for 1 cycle; write ack with rdata 0x0000; read returns 0x1234.
4. Reset asserted during WAIT -> all outputs 0 immediately; no rsp; after release, simultaneous valids grant port 0 first.
5. Parameter sweep MEM_LAT=0 and MEM_LAT=7 -> rsp at T+2 and T+9 respectively, with correct data.
6. MEM_ARB_PERF_EN defined, 3 contended IDLE cycles plus 2 grants each -> perf_conflict=3, perf_grant0=2, perf_grant1=2; counts forced near saturation stop at 0xFFFF.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Optional counters elsewhere are enabled by the MEM_ARB_PERF_EN macro.
package mem_arb_pkg;

   localparam int ADDR_W_DEF  = 16;
   localparam int DATA_W_DEF  = 16;
   localparam int MEM_LAT_DEF = 1;
   localparam int MEM_LAT_MAX = 7;
   localparam int LAT_CNT_W   = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_t;

endpackage

// File: rtl/mem_arb_rr2.sv
// Two-way round-robin pick: on a tie the port that did not win last time is chosen.
module mem_arb_rr2 (
   input  logic valid0,
   input  logic valid1,
   input  logic last_grant,
   output logic grant,
   output logic any
);

   assign any   = valid0 | valid1;
   assign grant = (valid0 && valid1) ? ~last_grant : valid1;

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported memory between two requesters (accept/issue/wait/respond).
// Define MEM_ARB_PERF_EN to add saturating grant and conflict counters.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int MEM_LAT = MEM_LAT_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0_valid,
   input  logic              req0_we,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              req0_ready,
   output logic              rsp0_valid,
   output logic [DATA_W-1:0] rsp0_rdata,
   input  logic              req1_valid,
   input  logic              req1_we,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              req1_ready,
   output logic              rsp1_valid,
   output logic [DATA_W-1:0] rsp1_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
`ifdef MEM_ARB_PERF_EN
   ,
   output logic [15:0]       perf_grant0,
   output logic [15:0]       perf_grant1,
   output logic [15:0]       perf_conflict
`endif
);

   // Out-of-range latencies are clamped to what the 3-bit wait counter can express.
   localparam int LAT_EFF = (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX :
                            ((MEM_LAT < 0) ? 0 : MEM_LAT);
   localparam logic [LAT_CNT_W-1:0] LAT_LOAD =
      (LAT_EFF == 0) ? '0 : LAT_CNT_W'(LAT_EFF - 1);

   arb_state_t             state_reg, state_next;
   logic [LAT_CNT_W-1:0]   cnt_reg, cnt_next;
   logic                   last_grant_reg;
   logic                   port_reg;
   logic                   we_reg;
   logic [ADDR_W-1:0]      addr_reg;
   logic [DATA_W-1:0]      wdata_reg;
   logic [DATA_W-1:0]      rsp0_rdata_reg, rsp1_rdata_reg;
   logic [DATA_W-1:0]      cap_data;
   logic                   grant, any;
   logic                   accept, capture;

   mem_arb_rr2 u_rr2 (
      .valid0     (req0_valid),
      .valid1     (req1_valid),
      .last_grant (last_grant_reg),
      .grant      (grant),
      .any        (any)
   );

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      accept     = 1'b0;
      capture    = 1'b0;
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      case (state_reg)
         IDLE: begin
            if (any && !reset) begin
               accept     = 1'b1;
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            mem_en    = 1'b1;
            mem_we    = we_reg;
            mem_addr  = addr_reg;
            mem_wdata = wdata_reg;
            if (LAT_EFF == 0) begin
               capture    = 1'b1;
               state_next = RESP;
            end else begin
               cnt_next   = LAT_LOAD;
               state_next = WAIT;
            end
         end
         WAIT: begin
            if (cnt_reg == '0) begin
               capture    = 1'b1;
               state_next = RESP;
            end else begin
               cnt_next = cnt_reg - 1'b1;
            end
         end
         RESP: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Writes are acknowledged with zero data so the response path is uniform.
   assign cap_data = we_reg ? '0 : mem_rdata;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg      <= IDLE;
         cnt_reg        <= '0;
         last_grant_reg <= 1'b1;
         port_reg       <= 1'b0;
         we_reg         <= 1'b0;
         addr_reg       <= '0;
         wdata_reg      <= '0;
         rsp0_rdata_reg <= '0;
         rsp1_rdata_reg <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (accept) begin
            last_grant_reg <= grant;
            port_reg       <= grant;
            we_reg         <= grant ? req1_we    : req0_we;
            addr_reg       <= grant ? req1_addr  : req0_addr;
            wdata_reg      <= grant ? req1_wdata : req0_wdata;
         end
         if (capture) begin
            if (port_reg) begin
               rsp1_rdata_reg <= cap_data;
            end else begin
               rsp0_rdata_reg <= cap_data;
            end
         end
      end
   end

   assign req0_ready = accept && !grant;
   assign req1_ready = accept && grant;
   assign rsp0_valid = (state_reg == RESP) && !port_reg;
   assign rsp1_valid = (state_reg == RESP) && port_reg;
   assign rsp0_rdata = rsp0_rdata_reg;
   assign rsp1_rdata = rsp1_rdata_reg;
   assign busy       = (state_reg != IDLE);

`ifdef MEM_ARB_PERF_EN
   logic [15:0] perf_grant0_reg, perf_grant1_reg, perf_conflict_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_grant0_reg   <= '0;
         perf_grant1_reg   <= '0;
         perf_conflict_reg <= '0;
      end else begin
         if (accept && !grant && perf_grant0_reg != 16'hFFFF) begin
            perf_grant0_reg <= perf_grant0_reg + 16'd1;
         end
         if (accept && grant && perf_grant1_reg != 16'hFFFF) begin
            perf_grant1_reg <= perf_grant1_reg + 16'd1;
         end
         if (state_reg == IDLE && req0_valid && req1_valid && perf_conflict_reg != 16'hFFFF) begin
            perf_conflict_reg <= perf_conflict_reg + 16'd1;
         end
      end
   end

   assign perf_grant0   = perf_grant0_reg;
   assign perf_grant1   = perf_grant1_reg;
   assign perf_conflict = perf_conflict_reg;
`endif

endmodule
